rom_arbiter: RTL
================

# rom_arbiter

Sequencer and arbiter for the shared 16-bit PSRAM ROM bus. It replaces the ad-hoc state machine in the top level with one block that grants the bus to three requesters: SNES (hard real-time), MCU (SPI-driven read/write) and the CX4 core (read-only fetches). For each granted access it drives the address, write-enable and write data, and returns read bytes and ready flags to the requester. SD DMA override of the bus stays outside this block.

## Interface
Parameters:
- `RD_WAIT_SNES`, 4: extra wait cycles for an SNES read.
- `WR_WAIT_SNES`, 5: extra wait cycles for an SNES write, counted from data capture.
- `RD_WAIT_MCU`, 6: extra wait cycles for an MCU read.
- `WR_WAIT_MCU`, 6: extra wait cycles for an MCU write.
- `RD_WAIT_CX4`, 6: extra wait cycles for a CX4 read.
- `RECOVER`, 2: idle cycles after every MCU access.

Ports:
- `CLK`, in, 1: system clock (CLK2 domain).
- `RST`, in, 1: asynchronous, active-high reset.
- `snes_rd_start`, in, 1: one-cycle strobe, SNES read cycle begins (already filtered for IS_CART and ~cx4_active).
- `snes_wr_start`, in, 1: one-cycle strobe, SNES write begins.
- `snes_addr`, in, 24: mapped SNES address.
- `snes_writable`, in, 1: target is writable (IS_WRITABLE).
- `snes_wdata`, in, 8: SNES data bus.
- `snes_rdata`, out, 8: byte returned to SNES.
- `mcu_rrq` / `mcu_wrq`, in, 1 each: one-cycle MCU read/write requests.
- `mcu_addr`, in, 24: MCU address.
- `mcu_wdata`, in, 8: MCU write byte.
- `mcu_rdata`, out, 8: MCU read byte.
- `mcu_rdy`, out, 1: high when no MCU request is outstanding.
- `cx4_rrq`, in, 1: one-cycle CX4 read request.
- `cx4_addr`, in, 24: CX4 address.
- `cx4_rdata`, out, 8: CX4 read byte.
- `cx4_rdy`, out, 1: high when no CX4 request is outstanding.
- `cx4_active`, in, 1: CX4 owns the cartridge; SNES and MCU are blocked.
- `rom_addr`, out, 23: word address, `addr[23:1]`.
- `rom_addr0`, out, 1: byte lane select.
- `rom_din`, in, 16: PSRAM read data.
- `rom_dout`, out, 8: write byte, replicated onto the lane by the top level.
- `rom_we_n`, out, 1: active-low write enable.
- `grant`, out, 2: current owner, 0 = idle, 1 = SNES, 2 = MCU, 3 = CX4.

## Operation
- States: IDLE, SNES_RD, SNES_WR_SETUP (2 cycles), SNES_WR, MCU_RD, MCU_WR, CX4_RD, END, RECOVER.
- Requests are latched as pending flags: `mcu_rd_pend`, `mcu_wr_pend`, `cx4_pend`, `snes_pend`.
- A pending flag clears in the END cycle of its access.
- Arbitration in IDLE, highest first:
  - SNES pending.
  - CX4 pending.
  - MCU read, then MCU write, only when `cx4_active` is low.
- SNES preemption:
  - A SNES strobe aborts an in-progress MCU_RD or CX4_RD. The victim's pending flag stays set and the access restarts from the beginning later.
  - MCU_WR is never aborted. The SNES request waits as pending.
- SNES_WR: `rom_we_n` = `~snes_writable`. Data is captured from `snes_wdata` after the setup cycles.
- Byte select: `rom_addr0` = 1 selects `rom_din[7:0]`, otherwise `rom_din[15:8]`.
- Read data registers update on every cycle of the read state, so the last sample wins.
- `rom_addr` holds the address latched at grant for the whole access.

## Timing
- A read with wait W spends W+1 cycles in its read state, then 1 END cycle.
- `*_rdy` returns high the cycle after END. Example: MCU read with W=6 gives rdy low for 9 cycles after the request cycle.
- An MCU access is followed by RECOVER cycles before IDLE. The total MCU occupancy is W+1+1+RECOVER.
- MCU_WR: `rom_we_n` is low for exactly WR_WAIT_MCU+1 cycles, and high during END and RECOVER.
- `mcu_rdy` and `cx4_rdy` drop in the cycle after their request.
- Simultaneous `mcu_rrq` and `mcu_wrq`: the read wins and the write is dropped.
- A request arriving while the same requester is already pending is ignored.
- Reset values:
  - State IDLE and all pending flags 0.
  - `rom_we_n` = 1, `mcu_rdy` = 1, `cx4_rdy` = 1.
  - `grant` = 0, all rdata = 0, `rom_addr` = 0.
- Reset mid-access deasserts `rom_we_n` immediately, because reset is asynchronous.
- Wait counters are 4 bits. Parameters above 15 are illegal.

## Structure
- Shared package `rom_arb_pkg`: state encoding (one-hot), grant codes, default wait constants.
- A single sub-module `rom_wait_ctr` (loadable 4-bit down-counter with a zero flag), reused by all states.

## Test plan
- MCU read at 0x000123 with `rom_din` = 0xAB55:
  - `rom_addr0` = 1, so `mcu_rdata` = 0x55.
  - `mcu_rdy` is low for 9 cycles.
- MCU write of 0x5A to 0x000010:
  - `rom_we_n` is low for 7 cycles with `rom_dout` = 0x5A.
  - Then 2 recovery cycles, then `mcu_rdy` = 1.
- CX4 read in flight, `snes_rd_start` at cycle 3:
  - `grant` goes to 1.
  - After the SNES END, the CX4 read restarts and returns the correct byte.
- MCU write in flight plus `snes_wr_start`:
  - The write completes untouched.
  - The SNES write starts in the cycle after RECOVER ends.
- `cx4_active` = 1 with `mcu_rrq` asserted: the MCU stays pending until `cx4_active` drops.
- `RST` pulsed during MCU_WR: `rom_we_n` = 1 asynchronously, state IDLE, `mcu_rdy` = 1.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the PSRAM ROM bus arbiter: state encoding, grant codes
// and default wait-cycle counts.
package rom_arb_pkg;

  localparam int CTR_W = 4;

  localparam logic [8:0] ST_IDLE          = 9'b0_0000_0001;
  localparam logic [8:0] ST_SNES_RD       = 9'b0_0000_0010;
  localparam logic [8:0] ST_SNES_WR_SETUP = 9'b0_0000_0100;
  localparam logic [8:0] ST_SNES_WR       = 9'b0_0000_1000;
  localparam logic [8:0] ST_MCU_RD        = 9'b0_0001_0000;
  localparam logic [8:0] ST_MCU_WR        = 9'b0_0010_0000;
  localparam logic [8:0] ST_CX4_RD        = 9'b0_0100_0000;
  localparam logic [8:0] ST_END           = 9'b0_1000_0000;
  localparam logic [8:0] ST_RECOVER       = 9'b1_0000_0000;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_SNES = 2'd1,
    GNT_MCU  = 2'd2,
    GNT_CX4  = 2'd3
  } grant_t;

  localparam int DEF_RD_WAIT_SNES = 4;
  localparam int DEF_WR_WAIT_SNES = 5;
  localparam int DEF_RD_WAIT_MCU  = 6;
  localparam int DEF_WR_WAIT_MCU  = 6;
  localparam int DEF_RD_WAIT_CX4  = 6;
  localparam int DEF_RECOVER      = 2;
  localparam int SNES_SETUP       = 2;

  // addr0 = 1 picks the low byte of the 16-bit word
  function automatic logic [7:0] lane_byte(input logic [15:0] din, input logic sel);
    return sel ? din[7:0] : din[15:8];
  endfunction

endpackage

// File: rtl/rom_wait_ctr.sv
// Loadable down-counter shared by every timed state of the arbiter; stops at zero.
module rom_wait_ctr
  import rom_arb_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  output logic             zero
);

  logic [CTR_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - CTR_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rom_arbiter.sv
// Grants the shared PSRAM ROM bus to SNES, MCU and CX4, sequences each access
// and returns read bytes and ready flags to the requesters.
//
// state            | meaning
// IDLE             | bus free, arbitrate pending requests
// SNES_RD          | SNES read, RD_WAIT_SNES+1 cycles
// SNES_WR_SETUP    | 2 cycles before SNES write data is valid
// SNES_WR          | SNES write, WR_WAIT_SNES+1 cycles
// MCU_RD / MCU_WR  | MCU access, wait+1 cycles; read is abortable by SNES
// CX4_RD           | CX4 fetch, RD_WAIT_CX4+1 cycles; abortable by SNES
// END              | one cycle, clears the owner's pending flag
// RECOVER          | idle gap after MCU accesses, then arbitrate
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int RD_WAIT_SNES = DEF_RD_WAIT_SNES,
  parameter int WR_WAIT_SNES = DEF_WR_WAIT_SNES,
  parameter int RD_WAIT_MCU  = DEF_RD_WAIT_MCU,
  parameter int WR_WAIT_MCU  = DEF_WR_WAIT_MCU,
  parameter int RD_WAIT_CX4  = DEF_RD_WAIT_CX4,
  parameter int RECOVER      = DEF_RECOVER
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        snes_rd_start,
  input  logic        snes_wr_start,
  input  logic [23:0] snes_addr,
  input  logic        snes_writable,
  input  logic [7:0]  snes_wdata,
  output logic [7:0]  snes_rdata,
  input  logic        mcu_rrq,
  input  logic        mcu_wrq,
  input  logic [23:0] mcu_addr,
  input  logic [7:0]  mcu_wdata,
  output logic [7:0]  mcu_rdata,
  output logic        mcu_rdy,
  input  logic        cx4_rrq,
  input  logic [23:0] cx4_addr,
  output logic [7:0]  cx4_rdata,
  output logic        cx4_rdy,
  input  logic        cx4_active,
  output logic [22:0] rom_addr,
  output logic        rom_addr0,
  input  logic [15:0] rom_din,
  output logic [7:0]  rom_dout,
  output logic        rom_we_n,
  output logic [1:0]  grant
);

  logic [8:0]       state, state_nx;
  grant_t           grant_q, arb_sel, start_sel;
  logic             arb_wr, start_wr, do_start, clr_pend, capture, ld, ctr_zero;
  logic [CTR_W-1:0] ld_val;
  logic [23:0]      start_addr;

  logic        snes_pend, snes_pend_wr, snes_wp;
  logic [23:0] snes_addr_q;
  logic        mcu_rd_pend, mcu_wr_pend;
  logic [23:0] mcu_addr_q;
  logic [7:0]  mcu_wdata_q;
  logic        cx4_pend;
  logic [23:0] cx4_addr_q;

  logic snes_new, snes_new_wr, snes_any, snes_any_wr, mcu_new, cx4_new, wr_active_nx;

  assign snes_new    = (snes_rd_start | snes_wr_start) & ~snes_pend;
  assign snes_new_wr = snes_wr_start & ~snes_rd_start;
  assign snes_any    = snes_pend | snes_new;
  assign snes_any_wr = snes_pend ? snes_pend_wr : snes_new_wr;
  assign mcu_new     = (mcu_rrq | mcu_wrq) & ~(mcu_rd_pend | mcu_wr_pend);
  assign cx4_new     = cx4_rrq & ~cx4_pend;

  always_comb begin
    arb_sel = GNT_IDLE;
    arb_wr  = 1'b0;
    if (snes_pend) begin
      arb_sel = GNT_SNES;
      arb_wr  = snes_pend_wr;
    end else if (cx4_pend) begin
      arb_sel = GNT_CX4;
    end else if (!cx4_active && mcu_rd_pend) begin
      arb_sel = GNT_MCU;
    end else if (!cx4_active && mcu_wr_pend) begin
      arb_sel = GNT_MCU;
      arb_wr  = 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    do_start  = 1'b0;
    start_sel = arb_sel;
    start_wr  = arb_wr;
    ld        = 1'b0;
    ld_val    = '0;
    clr_pend  = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: do_start = (arb_sel != GNT_IDLE);
      ST_MCU_RD, ST_CX4_RD: begin
        // a SNES request throws the victim back to pending; it restarts later
        if (snes_any) begin
          do_start  = 1'b1;
          start_sel = GNT_SNES;
          start_wr  = snes_any_wr;
        end else if (ctr_zero) begin
          state_nx = ST_END;
        end
      end
      ST_SNES_RD, ST_SNES_WR, ST_MCU_WR: if (ctr_zero) state_nx = ST_END;
      ST_SNES_WR_SETUP: if (ctr_zero) begin
        state_nx = ST_SNES_WR;
        ld       = 1'b1;
        ld_val   = CTR_W'(WR_WAIT_SNES);
        capture  = 1'b1;
      end
      ST_END: begin
        clr_pend = 1'b1;
        if (grant_q == GNT_MCU && RECOVER != 0) begin
          state_nx = ST_RECOVER;
          ld       = 1'b1;
          ld_val   = CTR_W'(RECOVER - 1);
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RECOVER: if (ctr_zero) begin
        state_nx = ST_IDLE;
        do_start = (arb_sel != GNT_IDLE);
      end
      default: state_nx = ST_IDLE;
    endcase
    if (do_start) begin
      ld = 1'b1;
      case (start_sel)
        GNT_SNES: begin
          state_nx = start_wr ? ST_SNES_WR_SETUP : ST_SNES_RD;
          ld_val   = start_wr ? CTR_W'(SNES_SETUP - 1) : CTR_W'(RD_WAIT_SNES);
        end
        GNT_CX4: begin
          state_nx = ST_CX4_RD;
          ld_val   = CTR_W'(RD_WAIT_CX4);
        end
        default: begin
          state_nx = start_wr ? ST_MCU_WR : ST_MCU_RD;
          ld_val   = start_wr ? CTR_W'(WR_WAIT_MCU) : CTR_W'(RD_WAIT_MCU);
        end
      endcase
    end
  end

  always_comb begin
    case (start_sel)
      GNT_SNES: start_addr = snes_pend ? snes_addr_q : snes_addr;
      GNT_CX4:  start_addr = cx4_addr_q;
      default:  start_addr = mcu_addr_q;
    endcase
  end

  assign wr_active_nx = (state_nx == ST_MCU_WR) | ((state_nx == ST_SNES_WR) & snes_wp);

  rom_wait_ctr u_wait_ctr (
    .CLK      (CLK),
    .RST      (RST),
    .load     (ld),
    .load_val (ld_val),
    .zero     (ctr_zero)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      grant_q   <= GNT_IDLE;
      rom_addr  <= '0;
      rom_addr0 <= 1'b0;
      rom_dout  <= '0;
      rom_we_n  <= 1'b1;
    end else begin
      state    <= state_nx;
      rom_we_n <= ~wr_active_nx;
      if (do_start) begin
        grant_q   <= start_sel;
        rom_addr  <= start_addr[23:1];
        rom_addr0 <= start_addr[0];
        if (start_sel == GNT_MCU && start_wr) rom_dout <= mcu_wdata_q;
      end else if (state_nx == ST_IDLE) begin
        grant_q <= GNT_IDLE;
      end
      if (capture) rom_dout <= snes_wdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snes_pend    <= 1'b0;
      snes_pend_wr <= 1'b0;
      snes_wp      <= 1'b0;
      snes_addr_q  <= '0;
      mcu_rd_pend  <= 1'b0;
      mcu_wr_pend  <= 1'b0;
      mcu_addr_q   <= '0;
      mcu_wdata_q  <= '0;
      cx4_pend     <= 1'b0;
      cx4_addr_q   <= '0;
    end else begin
      if (clr_pend && grant_q == GNT_SNES) begin
        snes_pend <= 1'b0;
      end else if (snes_new) begin
        snes_pend    <= 1'b1;
        snes_pend_wr <= snes_new_wr;
        snes_wp      <= snes_writable;
        snes_addr_q  <= snes_addr;
      end
      if (clr_pend && grant_q == GNT_MCU) begin
        mcu_rd_pend <= 1'b0;
        mcu_wr_pend <= 1'b0;
      end else if (mcu_new) begin
        mcu_rd_pend <= mcu_rrq;
        mcu_wr_pend <= ~mcu_rrq;
        mcu_addr_q  <= mcu_addr;
        mcu_wdata_q <= mcu_wdata;
      end
      if (clr_pend && grant_q == GNT_CX4) begin
        cx4_pend <= 1'b0;
      end else if (cx4_new) begin
        cx4_pend   <= 1'b1;
        cx4_addr_q <= cx4_addr;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snes_rdata <= '0;
      mcu_rdata  <= '0;
      cx4_rdata  <= '0;
    end else begin
      if (state == ST_SNES_RD) snes_rdata <= lane_byte(rom_din, rom_addr0);
      if (state == ST_MCU_RD)  mcu_rdata  <= lane_byte(rom_din, rom_addr0);
      if (state == ST_CX4_RD)  cx4_rdata  <= lane_byte(rom_din, rom_addr0);
    end
  end

  assign grant   = grant_q;
  assign mcu_rdy = ~(mcu_rd_pend | mcu_wr_pend);
  assign cx4_rdy = ~cx4_pend;

endmodule
